// File: rtl/cpu_mem_bridge.sv
// CPU-to-SRAM bridge: decodes a CPU request, runs one SRAM access (or flags an
// out-of-range error) and returns a single-cycle ack. One transaction at a time.
module cpu_mem_bridge #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SRAM_AW    = 10,
    parameter int unsigned           RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_err,
    output logic                  busy,
    output logic [7:0]            err_count,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StRdWait,
        StAck,
        StRecover
    } state_e;

    // RD_LATENCY is 1..4, so the wait counter never exceeds 3.
    localparam logic [1:0] CntLoad = 2'(RD_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    sram_en_q, sram_en_d;
    logic                    sram_we_q, sram_we_d;
    logic [SRAM_AW-1:0]      sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]   sram_wdata_q, sram_wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic accept;
    logic out_of_range;
    logic unused_addr_lsb;

    // Byte-lane bits carry no meaning for word accesses.
    assign unused_addr_lsb = ^mem_addr[1:0];

    assign accept       = (state_q == StIdle) && mem_req;
    assign out_of_range = |mem_addr[ADDR_WIDTH-1:SRAM_AW+2];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the read-wait counter advances alongside the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    state_d = out_of_range ? StAck : StAccess;
                end
            end
            StAccess: begin
                // sram_we_q still holds the direction of the access in flight.
                if (sram_we_q) begin
                    state_d = StAck;
                end else begin
                    state_d = StRdWait;
                    cnt_d   = CntLoad;
                end
            end
            StRdWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StAck:     state_d = StRecover;
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next-state: SRAM strobes, read capture and error bookkeeping.
    always_comb begin
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        err_cnt_d    = err_cnt_q;
        if (accept) begin
            err_d = out_of_range;
            if (out_of_range) begin
                if (!mem_we) begin
                    rdata_d = ERR_DATA;
                end
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                sram_en_d    = 1'b1;
                sram_we_d    = mem_we;
                sram_addr_d  = mem_addr[SRAM_AW+1:2];
                sram_wdata_d = mem_wdata;
            end
        end
        if ((state_q == StRdWait) && (cnt_q == 2'd0)) begin
            rdata_d = sram_rdata;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            cnt_q        <= cnt_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Outputs: ack/err/busy decode from state, the rest come straight from registers.
    always_comb begin
        mem_ack    = (state_q == StAck);
        mem_err    = (state_q == StAck) && err_q;
        busy       = (state_q != StIdle);
        mem_rdata  = rdata_q;
        err_count  = err_cnt_q;
        sram_en    = sram_en_q;
        sram_we    = sram_we_q;
        sram_addr  = sram_addr_q;
        sram_wdata = sram_wdata_q;
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: transaction-level reference model checked every
// cycle, an SRAM environment model, and directed scenarios with literal values.
module tb_cpu_mem_bridge;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        busy;
    logic [7:0]  err_count;
    logic        sram_en;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    always #5 clk = ~clk;

    cpu_mem_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SRAM_AW    (10),
        .RD_LATENCY (L),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err),
        .busy       (busy),
        .err_count  (err_count),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [31:0] sram_arr [1024];
    logic [31:0] ref_mem  [1024];

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 ^ 32'(i * 32'h0001_0003);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_arr[i] = init_val(i);
            ref_mem[i]  = init_val(i);
        end
    end

    // SRAM environment: executes the DUT strobes, returns read data L cycles later.
    int          rd_cycle = -1;
    logic [31:0] rd_data  = 32'h0;
    always @(posedge clk) begin
        if (sram_en === 1'b1) begin
            if (sram_we === 1'b1) begin
                sram_arr[sram_addr] = sram_wdata;
            end else begin
                rd_cycle = cyc + L;
                rd_data  = sram_arr[sram_addr];
            end
        end
        cyc = cyc + 1;
        #1;
        sram_rdata = (cyc == rd_cycle) ? rd_data : (32'hBAD0_0000 ^ 32'(cyc));
    end

    // Reference model: one transaction record, timing from the access rules.
    bit          armed = 1'b0;
    bit          rst_seen = 1'b0;
    bit          act = 1'b0;
    int          t_n, t_ack, t_idx;
    bit          t_oor, t_we;
    logic [31:0] t_wd;
    int          e_cnt = 0;
    logic [31:0] e_rdata = 32'h0;

    always @(negedge clk) begin
        int  k;
        bit  ack_e, en_e;
        k = cyc;
        if (rst_seen) begin
            armed   = 1'b1;
            act     = 1'b0;
            e_cnt   = 0;
            e_rdata = 32'h0;
        end
        if (armed) begin
            if (act && k > t_ack + 1) act = 1'b0;
            if (act && k == t_ack) begin
                if (t_oor && e_cnt < 255) e_cnt++;
                if (!t_we) e_rdata = t_oor ? 32'hDEAD_BEEF : ref_mem[t_idx];
            end
            ack_e = act && (k == t_ack);
            en_e  = act && !t_oor && (k == t_n + 1);
            chk("ack", 32'(mem_ack), 32'(ack_e));
            chk("err", 32'(mem_err), 32'(ack_e && t_oor));
            chk("busy", 32'(busy), 32'(act));
            chk("err_count", 32'(err_count), 32'(e_cnt));
            chk("rdata", mem_rdata, e_rdata);
            chk("sram_en", 32'(sram_en), 32'(en_e));
            chk("sram_we", 32'(sram_we), 32'(en_e && t_we));
            if (en_e) begin
                chk("sram_addr", 32'(sram_addr), 32'(t_idx));
                if (t_we) chk("sram_wdata", sram_wdata, t_wd);
            end
        end
        rst_seen = rst;
        if (armed && !rst && !act && mem_req === 1'b1) begin
            act   = 1'b1;
            t_n   = k;
            t_we  = mem_we;
            t_oor = (mem_addr >= 32'h0000_1000);
            t_idx = int'(mem_addr >> 2) & 1023;
            t_wd  = mem_wdata;
            t_ack = k + (t_oor ? 1 : (t_we ? 2 : 2 + L));
            if (!t_oor && t_we) ref_mem[t_idx] = t_wd;
        end
    end

    // One CPU access; returns latency from the sampled cycle and snapshots.
    task automatic do_access(input bit now, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output int lat, output logic [31:0] rd,
                             output logic er, output logic en1, output logic we1,
                             output logic [31:0] addr1, output logic busy_all);
        int s;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        s = cyc; lat = -1; rd = 32'h0; er = 1'b0;
        en1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; busy_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc == s + 1) begin
                en1 = sram_en; we1 = sram_we; addr1 = 32'(sram_addr);
            end
            if (cyc > s && busy !== 1'b1) busy_all = 1'b0;
            if (mem_ack === 1'b1) begin
                lat = cyc - s; rd = mem_rdata; er = mem_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_req = 1'b0;
    endtask

    initial begin
        int          lat, s, a1, a2, acks;
        logic [31:0] rd, ad1, rd2;
        logic        er, en1, we1, ba;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ack", 32'(mem_ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_sram_en", 32'(sram_en), 32'h0);

        // In-range write
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, lat, rd, er, en1, we1, ad1, ba);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_en", 32'(en1), 32'h1);
        chk("wr_we", 32'(we1), 32'h1);
        chk("wr_addr", ad1, 32'd4);
        chk("wr_err", 32'(er), 32'h0);

        // In-range read
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, en1, we1, ad1, ba);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_data", rd, 32'h1234_5678);
        chk("rd_err", 32'(er), 32'h0);
        chk("rd_busy", 32'(ba), 32'h1);
        chk("rd_en", 32'(en1), 32'h1);

        // Out-of-range read
        do_access(1'b0, 1'b0, 32'h0000_1000, 32'h0, lat, rd, er, en1, we1, ad1, ba);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", 32'(er), 32'h1);
        chk("oor_rdata", rd, 32'hDEAD_BEEF);
        chk("oor_no_en", 32'(en1), 32'h0);
        chk("oor_count", 32'(err_count), 32'd1);

        // Top word with byte-lane bits set, then read back
        do_access(1'b0, 1'b1, 32'h0000_0FFF, 32'hA5A5_5A5A, lat, rd, er, en1, we1, ad1, ba);
        chk("top_wr_addr", ad1, 32'd1023);
        do_access(1'b0, 1'b0, 32'h0000_0FFC, 32'h0, lat, rd, er, en1, we1, ad1, ba);
        chk("top_rd_data", rd, 32'hA5A5_5A5A);

        // Out-of-range write leaves read data and memory alone
        do_access(1'b0, 1'b1, 32'h8000_0000, 32'h1111_1111, lat, rd, er, en1, we1, ad1, ba);
        chk("oor_wr_lat", 32'(lat), 32'd1);
        chk("oor_wr_err", 32'(er), 32'h1);
        chk("oor_wr_hold", mem_rdata, 32'hA5A5_5A5A);
        chk("oor_wr_count", 32'(err_count), 32'd2);

        // Unwritten location
        do_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, lat, rd, er, en1, we1, ad1, ba);
        chk("init_rd", rd, 32'hC0D6_0018);

        // Request held across two reads; address changed while the first is in flight
        @(posedge clk);
        #1 mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0010;
        s = cyc; a1 = -1; a2 = -1; acks = 0; rd2 = 32'h0;
        @(posedge clk);
        #1 mem_addr = 32'h0000_0014;
        for (int i = 0; i < 30 && a2 < 0; i++) begin
            @(negedge clk);
            if (mem_ack === 1'b1) begin
                acks++;
                if (a1 < 0) a1 = cyc;
                else begin
                    a2 = cyc; rd2 = mem_rdata;
                end
            end
        end
        @(posedge clk);
        #1 mem_req = 1'b0;
        chk("held_first_lat", 32'(a1 - s), 32'd4);
        chk("held_spacing", 32'(a2 - a1), 32'd6);
        chk("held_acks", 32'(acks), 32'd2);
        chk("held_rd2", rd2, 32'hC0DB_000F);

        // Reset during RD_WAIT aborts the read; write right after reset
        @(posedge clk);
        #1 mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0010;
        @(posedge clk);
        #1 mem_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk("abort_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_ack", 32'(mem_ack), 32'h0);
        chk("abort_err", 32'(mem_err), 32'h0);
        chk("abort_busy0", 32'(busy), 32'h0);
        chk("abort_rdata", mem_rdata, 32'h0);
        chk("abort_count", 32'(err_count), 32'h0);
        chk("abort_en", 32'(sram_en), 32'h0);
        chk("abort_we", 32'(sram_we), 32'h0);
        chk("abort_addr", 32'(sram_addr), 32'h0);
        chk("abort_wdata", sram_wdata, 32'h0);
        do_access(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, lat, rd, er, en1, we1, ad1, ba);
        chk("post_rst_wr_lat", 32'(lat), 32'd2);

        // Error counter saturation
        for (int i = 0; i < 255; i++) begin
            do_access(1'b0, i[0], 32'h0000_1000 | 32'(i << 2), 32'(i), lat, rd, er, en1, we1,
                      ad1, ba);
            if (i == 0) chk("sat_lat", 32'(lat), 32'd1);
        end
        chk("sat_255", 32'(err_count), 32'hFF);
        do_access(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, lat, rd, er, en1, we1, ad1, ba);
        chk("sat_256", 32'(err_count), 32'hFF);
        chk("sat_256_err", 32'(er), 32'h1);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
